// File: rtl/multicore_sync_pkg.sv
// Shared types and default constants for the multicore launch-and-join controller.
package multicore_sync_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT,
      DONE,
      ERR
   } state_e;

   localparam int DEF_NUM_CORES      = 3;
   localparam int DEF_START_PULSE    = 2;
   localparam int DEF_CNT_W          = 32;
   localparam int DEF_TIMEOUT_CYCLES = 100000;

endpackage

// File: rtl/multicore_start_sync_finish_edge_capture.sv
// Registers each core's finish line and folds enabled rising edges into a sticky
// completion mask; clear wins over capture, and with neither the mask holds.
module finish_edge_capture
   import multicore_sync_pkg::*;
#(
   parameter int NUM_CORES = DEF_NUM_CORES
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_CORES-1:0] finish_in,
   input  logic [NUM_CORES-1:0] en_mask,
   input  logic                 clear,
   input  logic                 capture,
   output logic [NUM_CORES-1:0] done_mask,
   output logic [NUM_CORES-1:0] done_mask_next
);

   logic [NUM_CORES-1:0] finish_q;
   logic [NUM_CORES-1:0] done_mask_q;
   logic [NUM_CORES-1:0] done_mask_d;
   logic [NUM_CORES-1:0] rise;

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      rise        = finish_in & ~finish_q;
      done_mask_d = done_mask_q;
      if (clear) begin
         done_mask_d = '0;
      end else if (capture) begin
         done_mask_d = done_mask_q | (rise & en_mask);
      end
   end

   // NOTE: state registers use non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         finish_q    <= '0;
         done_mask_q <= '0;
      end else begin
         finish_q    <= finish_in;
         done_mask_q <= done_mask_d;
      end
   end

   assign done_mask      = done_mask_q;
   assign done_mask_next = done_mask_d;

endmodule

// File: rtl/multicore_start_sync.sv
// Launch-and-join controller: pulses start to the enabled cores, collects their
// finish edges, and reports completion, run length and watchdog timeout.
module multicore_start_sync
   import multicore_sync_pkg::*;
#(
   parameter int NUM_CORES      = DEF_NUM_CORES,
   parameter int START_PULSE    = DEF_START_PULSE,
   parameter int CNT_W          = DEF_CNT_W,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 go,
   input  logic                 abort,
   input  logic [NUM_CORES-1:0] core_en,
   input  logic [NUM_CORES-1:0] finish_in,
   output logic [NUM_CORES-1:0] start_out,
   output logic                 busy,
   output logic                 all_done,
   output logic                 timeout_err,
   output logic [NUM_CORES-1:0] done_mask,
   output logic [CNT_W-1:0]     cycle_count
);

   localparam int               PW          = (START_PULSE > 1) ? $clog2(START_PULSE) : 1;
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   state_e               state_q, state_d;
   logic [NUM_CORES-1:0] en_lat_q, en_lat_d;
   logic [PW-1:0]        pulse_cnt_q, pulse_cnt_d;
   logic [NUM_CORES-1:0] start_out_q, start_out_d;
   logic                 busy_q, busy_d;
   logic                 all_done_q, all_done_d;
   logic                 timeout_err_q, timeout_err_d;
   logic [CNT_W-1:0]     cycle_count_q, cycle_count_d;
   logic [CNT_W-1:0]     cycle_count_inc;
   logic                 clear, capture;
   logic [NUM_CORES-1:0] done_mask_next;

   finish_edge_capture #(
      .NUM_CORES (NUM_CORES)
   ) u_capture (
      .clk            (clk),
      .rst_n          (rst_n),
      .finish_in      (finish_in),
      .en_mask        (en_lat_q),
      .clear          (clear),
      .capture        (capture),
      .done_mask      (done_mask),
      .done_mask_next (done_mask_next)
   );

   always_comb begin
      state_d         = state_q;
      en_lat_d        = en_lat_q;
      pulse_cnt_d     = pulse_cnt_q;
      start_out_d     = '0;
      all_done_d      = 1'b0;
      timeout_err_d   = timeout_err_q;
      cycle_count_d   = cycle_count_q;
      clear           = 1'b0;
      capture         = 1'b0;
      cycle_count_inc = (cycle_count_q == CNT_MAX) ? cycle_count_q : cycle_count_q + CNT_W'(1);

      // Abort overrides everything and freezes mask, count and error flag.
      if (abort) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (go && (core_en != '0)) begin
                  state_d       = LAUNCH;
                  en_lat_d      = core_en;
                  clear         = 1'b1;
                  timeout_err_d = 1'b0;
                  cycle_count_d = CNT_W'(1);
                  start_out_d   = core_en;
                  pulse_cnt_d   = PW'(START_PULSE - 1);
               end
            end
            LAUNCH: begin
               capture = 1'b1;
               if (cycle_count_q >= TIMEOUT_VAL) begin
                  state_d       = ERR;
                  timeout_err_d = 1'b1;
               end else begin
                  cycle_count_d = cycle_count_inc;
                  if (pulse_cnt_q == '0) begin
                     state_d = WAIT;
                  end else begin
                     pulse_cnt_d = pulse_cnt_q - PW'(1);
                     start_out_d = en_lat_q;
                  end
               end
            end
            WAIT: begin
               capture = 1'b1;
               // Completion is tested before the watchdog so a same-cycle finish wins.
               if (done_mask_next == en_lat_q) begin
                  state_d    = DONE;
                  all_done_d = 1'b1;
               end else if (cycle_count_q >= TIMEOUT_VAL) begin
                  state_d       = ERR;
                  timeout_err_d = 1'b1;
               end else begin
                  cycle_count_d = cycle_count_inc;
               end
            end
            DONE, ERR: state_d = IDLE;
            default:   state_d = IDLE;
         endcase
      end

      busy_d = (state_d == LAUNCH) || (state_d == WAIT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         en_lat_q      <= '0;
         pulse_cnt_q   <= '0;
         start_out_q   <= '0;
         busy_q        <= 1'b0;
         all_done_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         cycle_count_q <= '0;
      end else begin
         state_q       <= state_d;
         en_lat_q      <= en_lat_d;
         pulse_cnt_q   <= pulse_cnt_d;
         start_out_q   <= start_out_d;
         busy_q        <= busy_d;
         all_done_q    <= all_done_d;
         timeout_err_q <= timeout_err_d;
         cycle_count_q <= cycle_count_d;
      end
   end

   assign start_out   = start_out_q;
   assign busy        = busy_q;
   assign all_done    = all_done_q;
   assign timeout_err = timeout_err_q;
   assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_multicore_start_sync.sv
// Randomised and directed bench for multicore_start_sync; each run's expected
// outcome is derived from the finish waveform by edge-finding arithmetic.
module tb_multicore_start_sync;

   localparam int NC   = 3;
   localparam int SP   = 2;
   localparam int CW   = 32;
   localparam int T    = 20;
   localparam int MAXK = 24;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          go = 1'b0;
   logic          abort = 1'b0;
   logic [NC-1:0] core_en = '0;
   logic [NC-1:0] finish_in = '0;
   logic [NC-1:0] start_out;
   logic          busy;
   logic          all_done;
   logic          timeout_err;
   logic [NC-1:0] done_mask;
   logic [CW-1:0] cycle_count;

   typedef struct packed {
      logic [NC-1:0] start_out;
      logic          busy;
      logic          all_done;
      logic          timeout_err;
      logic [NC-1:0] done_mask;
      logic [CW-1:0] cycle_count;
   } obs_t;

   obs_t          got;
   obs_t          exp_idle = '0;
   int            vectors = 0;
   int            miscompares = 0;
   logic [NC-1:0] fin [0:MAXK];

   multicore_start_sync #(
      .NUM_CORES      (NC),
      .START_PULSE    (SP),
      .CNT_W          (CW),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .go          (go),
      .abort       (abort),
      .core_en     (core_en),
      .finish_in   (finish_in),
      .start_out   (start_out),
      .busy        (busy),
      .all_done    (all_done),
      .timeout_err (timeout_err),
      .done_mask   (done_mask),
      .cycle_count (cycle_count)
   );

   assign got = {start_out, busy, all_done, timeout_err, done_mask, cycle_count};

   always #5 clk = ~clk;

   // Finish waveform where core c goes high at run cycle r_c and stays high (0 = never).
   task automatic set_levels(input int r0, input int r1, input int r2);
      for (int k = 0; k <= MAXK; k++) begin
         fin[k][0] = (r0 != 0) && (k >= r0);
         fin[k][1] = (r1 != 0) && (k >= r1);
         fin[k][2] = (r2 != 0) && (k >= r2);
      end
   endtask

   // Applies one run using fin[], checking every cycle against the expected outcome.
   task automatic run_one(input string name, input logic [NC-1:0] en, input int abort_at,
                          input bit hold_next);
      int            cap [NC];
      int            last;
      int            limit;
      int            kind; // 0 completed, 1 timed out, 2 aborted
      bit            all_seen;
      logic [NC-1:0] m;
      obs_t          e;

      for (int c = 0; c < NC; c++) begin
         cap[c] = 0;
         if (en[c]) begin
            for (int k = 1; k <= MAXK; k++) begin
               if (cap[c] == 0 && fin[k][c] && !fin[k-1][c]) cap[c] = k;
            end
         end
      end
      all_seen = 1'b1;
      last     = SP + 1;
      for (int c = 0; c < NC; c++) begin
         if (en[c]) begin
            if (cap[c] == 0) all_seen = 1'b0;
            else if (cap[c] > last) last = cap[c];
         end
      end
      if (all_seen && last <= T) begin
         kind = 0;
      end else begin
         kind = 1;
         last = T;
      end
      if (abort_at != 0 && abort_at <= last) begin
         kind = 2;
         last = abort_at;
      end

      @(negedge clk);
      vectors++;
      if (got !== exp_idle) begin
         miscompares++;
         $display("FAIL %s idle: got %h expected %h", name, got, exp_idle);
      end
      go        = 1'b1;
      core_en   = en;
      finish_in = fin[0];
      abort     = 1'b0;

      for (int k = 1; k <= last; k++) begin
         @(negedge clk);
         m = '0;
         for (int c = 0; c < NC; c++) if (en[c] && cap[c] != 0 && cap[c] < k) m[c] = 1'b1;
         e = '{start_out: (k <= SP) ? en : '0, busy: 1'b1, all_done: 1'b0, timeout_err: 1'b0,
               done_mask: m, cycle_count: CW'(k)};
         vectors++;
         if (got !== e) begin
            miscompares++;
            $display("FAIL %s run cycle %0d: got %h expected %h", name, k, got, e);
         end
         go        = 1'b0;
         finish_in = fin[k];
         abort     = (k == abort_at);
      end

      @(negedge clk);
      abort = 1'b0;
      limit = (kind == 2) ? last : last + 1;
      m = '0;
      for (int c = 0; c < NC; c++) if (en[c] && cap[c] != 0 && cap[c] < limit) m[c] = 1'b1;
      e = '{start_out: '0, busy: 1'b0, all_done: (kind == 0), timeout_err: (kind == 1),
            done_mask: m, cycle_count: CW'(last)};
      vectors++;
      if (got !== e) begin
         miscompares++;
         $display("FAIL %s end: got %h expected %h", name, got, e);
      end
      e.all_done = 1'b0;
      exp_idle   = e;
      go         = hold_next && (kind != 2);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if (got !== '0) begin
         miscompares++;
         $display("FAIL reset: got %h expected 0", got);
      end
      rst_n    = 1'b1;
      exp_idle = '0;
   endtask

   task automatic test_go_no_enable();
      @(negedge clk);
      go      = 1'b1;
      core_en = '0;
      repeat (3) begin
         @(negedge clk);
         vectors++;
         if (got !== exp_idle) begin
            miscompares++;
            $display("FAIL go_no_enable: got %h expected %h", got, exp_idle);
         end
      end
      go = 1'b0;
   endtask

   task automatic test_basic();
      set_levels(5, 10, 7);
      run_one("basic", 3'b111, 0, 1'b0);
   endtask

   task automatic test_partial();
      set_levels(6, 0, 8);
      fin[4][1] = 1'b1;
      fin[5][1] = 1'b1;
      run_one("partial", 3'b101, 0, 1'b0);
   endtask

   task automatic test_stale();
      set_levels(0, 3, 3);
      for (int k = 0; k <= MAXK; k++) fin[k][0] = (k <= 3) || (k >= 9);
      run_one("stale", 3'b111, 0, 1'b0);
   endtask

   task automatic test_timeout();
      set_levels(4, 6, 0);
      run_one("timeout", 3'b111, 0, 1'b0);
      set_levels(5, 10, 7);
      run_one("relaunch_after_timeout", 3'b111, 0, 1'b0);
   endtask

   task automatic test_simultaneous();
      set_levels(3, 5, 20);
      run_one("finish_at_timeout", 3'b111, 0, 1'b0);
      set_levels(5, 10, 7);
      run_one("abort", 3'b111, 6, 1'b0);
   endtask

   task automatic test_back_to_back();
      set_levels(2, 4, 3);
      run_one("b2b_first", 3'b111, 0, 1'b1);
      set_levels(6, 0, 0);
      run_one("b2b_second", 3'b001, 0, 1'b0);
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      go        = 1'b1;
      core_en   = 3'b110;
      finish_in = '0;
      @(negedge clk);
      go = 1'b0;
      vectors++;
      if (start_out !== 3'b110) begin
         miscompares++;
         $display("FAIL reset_mid_run start: got %b expected 110", start_out);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (got !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_run: got %h expected 0", got);
      end
      @(negedge clk);
      rst_n    = 1'b1;
      exp_idle = '0;
   endtask

   task automatic test_random();
      int            rise;
      int            stale_end;
      bit            stale;
      logic [NC-1:0] en;
      int            abort_at;
      for (int r = 0; r < 40; r++) begin
         en = NC'($urandom_range(1, 7));
         for (int c = 0; c < NC; c++) begin
            rise      = $urandom_range(1, 26);
            stale     = ($urandom_range(0, 3) == 0);
            stale_end = $urandom_range(0, 5);
            for (int k = 0; k <= MAXK; k++) begin
               fin[k][c] = (k >= rise) || (stale && k <= stale_end) ||
                           ($urandom_range(0, 11) == 0);
            end
         end
         abort_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 22) : 0;
         run_one("random", en, abort_at, bit'($urandom_range(0, 1)));
      end
      @(negedge clk);
      go = 1'b0;
   endtask

   initial begin
      test_reset();
      test_go_no_enable();
      test_basic();
      test_partial();
      test_stale();
      test_timeout();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
